// File: rtl/scan_chain_driver_pkg.sv
// Shared types for the scan chain driver: FSM state encoding and the
// width of the optional response fail counter.
package scan_chain_driver_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } state_e;

    localparam int FAIL_CNT_W = 16;

endpackage

// File: rtl/scan_shift_reg.sv
// Pattern serializer (PISO, MSB first onto SI) paired with the response
// deserializer (SIPO from SO), sharing one bit-position counter.
module scan_shift_reg #(
    parameter  int CHAIN_LEN = 16,
    localparam int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 load_i,
    input  logic                 clr_i,
    input  logic                 shift_i,
    input  logic [CHAIN_LEN-1:0] pat_i,
    input  logic                 so_i,
    output logic                 si_o,
    output logic                 cnt_last_o,
    output logic [CHAIN_LEN-1:0] unload_o,
    output logic [CHAIN_LEN-1:0] unload_next_o
);

    logic [CHAIN_LEN-1:0] piso_q, piso_d;
    logic [CHAIN_LEN-1:0] unload_q, unload_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 si_q, si_d;

    // The first SO sample (chain position CHAIN_LEN-1) ends up in the MSB.
    assign unload_next_o = {unload_q[CHAIN_LEN-2:0], so_i};

    always_comb begin
        piso_d   = piso_q;
        unload_d = unload_q;
        cnt_d    = cnt_q;
        si_d     = si_q;
        if (load_i) begin
            si_d   = pat_i[CHAIN_LEN-1];
            piso_d = {pat_i[CHAIN_LEN-2:0], 1'b0};
            cnt_d  = '0;
        end else if (clr_i) begin
            si_d   = 1'b0;
            piso_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            si_d     = piso_q[CHAIN_LEN-1];
            piso_d   = {piso_q[CHAIN_LEN-2:0], 1'b0};
            unload_d = unload_next_o;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            si_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            si_q  <= si_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        piso_q   <= piso_d;
        unload_q <= unload_d;
    end

    assign si_o       = si_q;
    assign cnt_last_o = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign unload_o   = unload_q;

endmodule

// File: rtl/scan_chain_driver.sv
// Scan chain tester engine: load pattern, capture, unload while the next
// pattern loads. Define SCAN_CHAIN_DRIVER_CMP_EN for expected-response compare.
module scan_chain_driver
    import scan_chain_driver_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) (
    input  logic                  CLK,
    input  logic                  RN,
    input  logic                  pat_valid,
    output logic                  pat_ready,
    input  logic [CHAIN_LEN-1:0]  pat_data,
    input  logic                  pat_last,
    output logic                  SE,
    output logic                  SI,
    input  logic                  SO,
    output logic                  chain_clk_en,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [CHAIN_LEN-1:0]  resp_data,
    output logic                  busy
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    ,
    input  logic [CHAIN_LEN-1:0]  pat_exp,
    output logic                  resp_mismatch,
    output logic [FAIL_CNT_W-1:0] resp_fail_cnt
`endif
);

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 have_cap_q, have_cap_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [CHAIN_LEN-1:0] resp_data_q, resp_data_d;
    logic                 pat_ready_q, pat_ready_d;
    logic                 se_q, se_d;
    logic                 clk_en_q, clk_en_d;

    logic                 load, clr, shift;
    logic                 cnt_last;
    logic [CHAIN_LEN-1:0] unload, unload_next;

    scan_shift_reg #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shift (
        .CLK           (CLK),
        .RN            (RN),
        .load_i        (load),
        .clr_i         (clr),
        .shift_i       (shift),
        .pat_i         (pat_data),
        .so_i          (SO),
        .si_o          (SI),
        .cnt_last_o    (cnt_last),
        .unload_o      (unload),
        .unload_next_o (unload_next)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        have_cap_d   = have_cap_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        load         = 1'b0;
        clr          = 1'b0;
        shift        = 1'b0;

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (pat_valid && pat_ready_q) begin
                    load    = 1'b1;
                    last_d  = pat_last;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_last) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Unload now holds the previous pattern's capture.
                if (have_cap_q) begin
                    resp_data_d  = unload;
                    resp_valid_d = 1'b1;
                end
                have_cap_d = 1'b1;
                if (last_q) begin
                    clr     = 1'b1;
                    state_d = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (!resp_valid_q) begin
                    shift = 1'b1;
                    if (cnt_last) begin
                        resp_data_d  = unload_next;
                        resp_valid_d = 1'b1;
                        have_cap_d   = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Chain-facing controls are registered from the next state so they
        // line up with the cycle the FSM spends in that state.
        pat_ready_d = (state_d == IDLE) && !resp_valid_d;
        se_d        = (state_d == SHIFT) || ((state_d == FLUSH) && !resp_valid_d);
        clk_en_d    = se_d || (state_d == CAPTURE);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q      <= IDLE;
            last_q       <= 1'b0;
            have_cap_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            pat_ready_q  <= 1'b0;
            se_q         <= 1'b0;
            clk_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            have_cap_q   <= have_cap_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            pat_ready_q  <= pat_ready_d;
            se_q         <= se_d;
            clk_en_q     <= clk_en_d;
        end
    end

    assign pat_ready    = pat_ready_q;
    assign SE           = se_q;
    assign chain_clk_en = clk_en_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign busy         = (state_q != IDLE);

`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    logic [CHAIN_LEN-1:0]  exp_q, cap_exp_q, resp_exp_q;
    logic [FAIL_CNT_W-1:0] fail_cnt_q;
    logic                  resp_set;

    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A response is only ever raised from an empty response slot.
    assign resp_set = resp_valid_d && !resp_valid_q;

    // Expected value follows the pattern: accept -> capture -> response.
    always_ff @(posedge CLK) begin
        if (load) begin
            exp_q <= pat_exp;
        end
        if (state_q == CAPTURE) begin
            cap_exp_q <= exp_q;
        end
        if (resp_set) begin
            resp_exp_q <= cap_exp_q;
        end
    end

    assign resp_mismatch = resp_valid_q && (|(resp_data_q ^ resp_exp_q));

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            fail_cnt_q <= '0;
        end else if (resp_valid_q && resp_ready && resp_mismatch) begin
            fail_cnt_q <= sat_inc(fail_cnt_q);
        end
    end

    assign resp_fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver with an inverting scan-flop chain model (D = ~Q);
// compare checks are enabled when SCAN_CHAIN_DRIVER_CMP_EN is defined.
module tb_scan_chain_driver;

    localparam int CHAIN_LEN = 16;

    logic        clk = 1'b0;
    logic        rn = 1'b0;
    logic        pat_valid = 1'b0;
    logic        pat_last = 1'b0;
    logic [15:0] pat_data = '0;
    logic        resp_ready = 1'b0;
    logic        pat_ready, se, si, so, clk_en, resp_valid, busy;
    logic [15:0] resp_data;
    logic [15:0] chain_q;
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    logic [15:0] pat_exp = '0;
    logic        resp_mismatch;
    logic [15:0] resp_fail_cnt;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clk_en) chain_q <= se ? {chain_q[14:0], si} : ~chain_q;
    end
    assign so = chain_q[15];

    scan_chain_driver #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .CLK          (clk),
        .RN           (rn),
        .pat_valid    (pat_valid),
        .pat_ready    (pat_ready),
        .pat_data     (pat_data),
        .pat_last     (pat_last),
        .SE           (se),
        .SI           (si),
        .SO           (so),
        .chain_clk_en (clk_en),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .busy         (busy)
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        ,
        .pat_exp       (pat_exp),
        .resp_mismatch (resp_mismatch),
        .resp_fail_cnt (resp_fail_cnt)
`endif
    );

    task automatic drive_pat(input logic [15:0] p, input logic last);
        int waited = 0;
        @(negedge clk);
        pat_valid = 1'b1;
        pat_data  = p;
        pat_last  = last;
        while (!pat_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (pat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pat_accept %h: pat_ready=%b after %0d cycles, required 1", p, pat_ready, waited);
            pat_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(~p);
            #1 pat_valid = 1'b0;
        end
    endtask

    task automatic take_resp(output logic [15:0] d, output logic mm, output logic got);
        int waited = 0;
        @(negedge clk);
        resp_ready = 1'b1;
        while (!resp_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        got = resp_valid;
        d   = resp_data;
        mm  = 1'b0;
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        mm  = resp_mismatch;
`endif
        if (got) @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic check_resp(input string name);
        logic [15:0] d, e;
        logic        mm, got;
        take_resp(d, mm, got);
        e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        n_cmp++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: no response within bound, required %h", name, e);
        end else if (d !== e) begin
            n_fail++;
            $display("FAIL %s: resp_data=%h, required %h", name, d, e);
        end
    endtask

    task automatic test_reset();
        rn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({se, si, clk_en, pat_ready, resp_valid, busy, resp_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: se=%b si=%b en=%b rdy=%b rv=%b busy=%b rd=%h, required all 0",
                     se, si, clk_en, pat_ready, resp_valid, busy, resp_data);
        end
        rn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: pat_ready=%b, required 1", pat_ready);
        end
    endtask

    task automatic test_quiet(input string name);
        int bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || busy !== 1'b0 || clk_en !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_quiet: %0d active cycles, %0d responses outstanding, required 0 and 0", name, bad, sb.size());
        end
    endtask

    task automatic test_single();
        logic [15:0] p = 16'hA5C3;
        logic        exp_se, exp_si;
        drive_pat(p, 1'b1);
        for (int c = 0; c < 33; c++) begin
            @(negedge clk);
            exp_se = (c != 16);
            exp_si = (c < 16) ? p[15 - c] : 1'b0;
            n_cmp++;
            if (se !== exp_se || clk_en !== 1'b1 || si !== exp_si || resp_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_seq c=%0d: se=%b en=%b si=%b rv=%b busy=%b, required se=%b en=1 si=%b rv=0 busy=1",
                         c, se, clk_en, si, resp_valid, busy, exp_se, exp_si);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b1 || clk_en !== 1'b0 || se !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: rv=%b en=%b se=%b, required rv=1 en=0 se=0", resp_valid, clk_en, se);
        end
        check_resp("single_resp");
        test_quiet("single");
    endtask

    task automatic test_back_to_back();
        drive_pat(16'h0001, 1'b0);
        drive_pat(16'h8000, 1'b1);
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_silent: resp_valid=%b at second accept, required 0", resp_valid);
        end
        check_resp("b2b_resp0");
        check_resp("b2b_resp1");
        test_quiet("b2b");
    endtask

    task automatic test_stall();
        int waited = 0;
        int bad = 0;
        drive_pat(16'h1234, 1'b0);
        drive_pat(16'hC0DE, 1'b1);
        while (!resp_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first_resp: resp_valid=%b, required 1", resp_valid);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pat_ready !== 1'b0 || clk_en !== 1'b0 || resp_valid !== 1'b1 || resp_data !== sb[0]) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d bad cycles (rdy=%b en=%b rv=%b rd=%h), required 0 (rdy=0 en=0 rv=1 rd=%h)",
                     bad, pat_ready, clk_en, resp_valid, resp_data, sb[0]);
        end
        check_resp("stall_resp0");
        check_resp("stall_resp1");
        test_quiet("stall");
    endtask

    task automatic test_reset_mid();
        drive_pat(16'h1111, 1'b0);
        repeat (7) @(negedge clk);
        #1 rn = 1'b0;
        #1;
        n_cmp++;
        if (se !== 1'b0 || clk_en !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 || pat_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: se=%b en=%b rv=%b busy=%b rdy=%b, required all 0",
                     se, clk_en, resp_valid, busy, pat_ready);
        end
        sb.delete();
        @(negedge clk);
        rn = 1'b1;
        drive_pat(16'hFFFF, 1'b1);
        check_resp("reset_mid_resp");
        test_quiet("reset_mid");
    endtask

`ifdef SCAN_CHAIN_DRIVER_CMP_EN
    task automatic test_compare();
        logic [15:0] d;
        logic        mm, got;
        n_cmp++;
        if (resp_fail_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL cmp_cnt_start: resp_fail_cnt=%0d, required 0", resp_fail_cnt);
        end
        pat_exp = 16'hFF00;
        drive_pat(16'h00FF, 1'b0);
        pat_exp = 16'h0000;
        drive_pat(16'h0F0F, 1'b1);
        take_resp(d, mm, got);
        n_cmp++;
        if (got !== 1'b1 || d !== sb[0] || mm !== |(sb[0] ^ 16'hFF00)) begin
            n_fail++;
            $display("FAIL cmp_resp0: got=%b data=%h mm=%b, required got=1 data=%h mm=0", got, d, mm, sb[0]);
        end
        void'(sb.pop_front());
        take_resp(d, mm, got);
        n_cmp++;
        if (got !== 1'b1 || d !== sb[0] || mm !== |(sb[0] ^ 16'h0000)) begin
            n_fail++;
            $display("FAIL cmp_resp1: got=%b data=%h mm=%b, required got=1 data=%h mm=1", got, d, mm, sb[0]);
        end
        void'(sb.pop_front());
        n_cmp++;
        if (resp_fail_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL cmp_fail_cnt: resp_fail_cnt=%0d, required 1", resp_fail_cnt);
        end
        test_quiet("cmp");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef SCAN_CHAIN_DRIVER_CMP_EN
        test_compare();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
